// File: rtl/hazard_unit_sb_if.sv
// Pipeline <-> hazard unit bundle: stage register addresses/enables in, stall/flush/forward controls out.
// HAZARD_PERF_CNT_EN adds the stall_cycles / sb_stall_cycles counter outputs.
interface hazard_unit_sb_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int OUTST_W  = 3
);
  logic [ADDR_W-1:0]   rs1_addr_d;
  logic [ADDR_W-1:0]   rs2_addr_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                rf_write_en_d;
  logic                long_op_d;
  logic                branch_inst_d;
  logic                bj_taken_d;
  logic [ADDR_W-1:0]   rs1_addr_e;
  logic [ADDR_W-1:0]   rs2_addr_e;
  logic [ADDR_W-1:0]   rf_dest_e;
  logic                rf_write_en_e;
  logic                mem_load_e;
  logic                long_issue_e;
  logic [ADDR_W-1:0]   rf_dest_m;
  logic                rf_write_en_m;
  logic                mem_load_m;
  logic [ADDR_W-1:0]   rf_dest_w;
  logic                rf_write_en_w;
  logic                long_done;
  logic [ADDR_W-1:0]   long_done_dest;
  logic                stall_fetch;
  logic                stall_decode;
  logic                flush_decode;
  logic                flush_execute;
  logic [1:0]          forward_rs1_select_d;
  logic [1:0]          forward_rs2_select_d;
  logic [1:0]          forward_rs1_select_e;
  logic [1:0]          forward_rs2_select_e;
  logic [NUM_REGS-1:0] busy_vec;
  logic [OUTST_W-1:0]  outst_cnt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]         stall_cycles;
  logic [31:0]         sb_stall_cycles;
`endif

  modport master (
    output rs1_addr_d, rs2_addr_d, rd_addr_d, rf_write_en_d, long_op_d,
           branch_inst_d, bj_taken_d, rs1_addr_e, rs2_addr_e, rf_dest_e,
           rf_write_en_e, mem_load_e, long_issue_e, rf_dest_m, rf_write_en_m,
           mem_load_m, rf_dest_w, rf_write_en_w, long_done, long_done_dest,
    input  stall_fetch, stall_decode, flush_decode, flush_execute,
           forward_rs1_select_d, forward_rs2_select_d,
           forward_rs1_select_e, forward_rs2_select_e, busy_vec, outst_cnt
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, sb_stall_cycles
`endif
  );

  modport slave (
    input  rs1_addr_d, rs2_addr_d, rd_addr_d, rf_write_en_d, long_op_d,
           branch_inst_d, bj_taken_d, rs1_addr_e, rs2_addr_e, rf_dest_e,
           rf_write_en_e, mem_load_e, long_issue_e, rf_dest_m, rf_write_en_m,
           mem_load_m, rf_dest_w, rf_write_en_w, long_done, long_done_dest,
    output stall_fetch, stall_decode, flush_decode, flush_execute,
           forward_rs1_select_d, forward_rs2_select_d,
           forward_rs1_select_e, forward_rs2_select_e, busy_vec, outst_cnt
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, sb_stall_cycles
`endif
  );
endinterface

// File: rtl/hazard_unit_sb.sv
// Hazard unit with load-use/branch stalls, M/W/long-done forwarding and a long-op scoreboard.
// Optional HAZARD_PERF_CNT_EN: saturating stall / scoreboard-stall cycle counters.
module hazard_unit_sb #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_OUTST = 4,
  parameter int OUTST_W   = 3
) (
  input logic            clk,
  input logic            reset,
  hazard_unit_sb_if.slave hz
);

  localparam logic [OUTST_W-1:0] CNT_MAX  = OUTST_W'(MAX_OUTST);
  localparam logic [OUTST_W-1:0] CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0]  X0       = '0;

  logic [NUM_REGS-1:0] busy_vec, busy_nxt;
  logic [OUTST_W-1:0]  outst_cnt, outst_nxt;
  logic                ld_stall, br_stall, sb_stall, full_stall, stall;
  logic                e_match_d, m_load_match_d;
  logic                issue_acc, done_acc;

  // Priority: long-unit result > M (non-load) > W > register file.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic              done,
    input logic [ADDR_W-1:0] done_dest,
    input logic              we_m,
    input logic              ld_m,
    input logic [ADDR_W-1:0] dest_m,
    input logic              we_w,
    input logic [ADDR_W-1:0] dest_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != X0) begin
      if (done && done_dest == src)             sel = 2'b11;
      else if (we_m && !ld_m && dest_m == src)  sel = 2'b10;
      else if (we_w && dest_w == src)           sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    e_match_d = hz.rf_write_en_e && hz.rf_dest_e != X0 &&
                (hz.rf_dest_e == hz.rs1_addr_d || hz.rf_dest_e == hz.rs2_addr_d);
    m_load_match_d = hz.rf_write_en_m && hz.mem_load_m && hz.rf_dest_m != X0 &&
                     (hz.rf_dest_m == hz.rs1_addr_d || hz.rf_dest_m == hz.rs2_addr_d);
    ld_stall   = hz.mem_load_e && hz.rf_dest_e != X0 &&
                 (hz.rf_dest_e == hz.rs1_addr_d || hz.rf_dest_e == hz.rs2_addr_d);
    br_stall   = hz.branch_inst_d && (e_match_d || m_load_match_d);
    // A done arriving this cycle still stalls; the busy bit only drops at the edge.
    sb_stall   = busy_vec[hz.rs1_addr_d] || busy_vec[hz.rs2_addr_d] ||
                 (hz.rf_write_en_d && busy_vec[hz.rd_addr_d]);
    full_stall = hz.long_op_d && outst_cnt == CNT_MAX && !hz.long_done;
    stall      = ld_stall || br_stall || sb_stall || full_stall;
  end

  assign hz.stall_decode  = stall;
  assign hz.stall_fetch   = stall;
  assign hz.flush_execute = stall;
  assign hz.flush_decode  = hz.bj_taken_d && !stall;

  assign hz.forward_rs1_select_d = fwd_sel(hz.rs1_addr_d, hz.long_done, hz.long_done_dest,
    hz.rf_write_en_m, hz.mem_load_m, hz.rf_dest_m, hz.rf_write_en_w, hz.rf_dest_w);
  assign hz.forward_rs2_select_d = fwd_sel(hz.rs2_addr_d, hz.long_done, hz.long_done_dest,
    hz.rf_write_en_m, hz.mem_load_m, hz.rf_dest_m, hz.rf_write_en_w, hz.rf_dest_w);
  assign hz.forward_rs1_select_e = fwd_sel(hz.rs1_addr_e, hz.long_done, hz.long_done_dest,
    hz.rf_write_en_m, hz.mem_load_m, hz.rf_dest_m, hz.rf_write_en_w, hz.rf_dest_w);
  assign hz.forward_rs2_select_e = fwd_sel(hz.rs2_addr_e, hz.long_done, hz.long_done_dest,
    hz.rf_write_en_m, hz.mem_load_m, hz.rf_dest_m, hz.rf_write_en_w, hz.rf_dest_w);

  // Out-of-range issue/done are dropped; a paired issue+done always balances.
  always_comb begin
    issue_acc = hz.long_issue_e && (outst_cnt != CNT_MAX || hz.long_done);
    done_acc  = hz.long_done && (outst_cnt != CNT_ZERO || hz.long_issue_e);
    outst_nxt = outst_cnt;
    if (issue_acc && !done_acc)      outst_nxt = outst_cnt + OUTST_W'(1);
    else if (done_acc && !issue_acc) outst_nxt = outst_cnt - OUTST_W'(1);
    busy_nxt = busy_vec;
    if (hz.long_done) busy_nxt[hz.long_done_dest] = 1'b0;
    if (issue_acc && hz.rf_dest_e != X0) busy_nxt[hz.rf_dest_e] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_vec  <= '0;
      outst_cnt <= '0;
    end else begin
      busy_vec  <= busy_nxt;
      outst_cnt <= outst_nxt;
    end
  end

  assign hz.busy_vec  = busy_vec;
  assign hz.outst_cnt = outst_cnt;

  a_done_underflow: assert property (@(posedge clk) disable iff (reset)
    !(hz.long_done && !hz.long_issue_e && outst_cnt == CNT_ZERO))
    else $error("long_done with no long op outstanding");

  a_issue_overflow: assert property (@(posedge clk) disable iff (reset)
    !(hz.long_issue_e && !hz.long_done && outst_cnt == CNT_MAX))
    else $error("long op issued with unit full");

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, sb_stall_cycles;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles    <= '0;
      sb_stall_cycles <= '0;
    end else begin
      if (stall)    stall_cycles    <= sat_inc(stall_cycles);
      if (sb_stall) sb_stall_cycles <= sat_inc(sb_stall_cycles);
    end
  end

  assign hz.stall_cycles    = stall_cycles;
  assign hz.sb_stall_cycles = sb_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: stalls, forwarding priority, scoreboard and async reset.
module tb_hazard_unit_sb;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_unit_sb_if #(.NUM_REGS(32), .ADDR_W(5), .OUTST_W(3)) hz ();

  hazard_unit_sb #(.NUM_REGS(32), .ADDR_W(5), .MAX_OUTST(4), .OUTST_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs1_addr_d = '0; hz.rs2_addr_d = '0; hz.rd_addr_d = '0;
    hz.rf_write_en_d = 0; hz.long_op_d = 0; hz.branch_inst_d = 0; hz.bj_taken_d = 0;
    hz.rs1_addr_e = '0; hz.rs2_addr_e = '0; hz.rf_dest_e = '0;
    hz.rf_write_en_e = 0; hz.mem_load_e = 0; hz.long_issue_e = 0;
    hz.rf_dest_m = '0; hz.rf_write_en_m = 0; hz.mem_load_m = 0;
    hz.rf_dest_w = '0; hz.rf_write_en_w = 0;
    hz.long_done = 0; hz.long_done_dest = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b1;
    next();
    chk("rst_busy", 64'(hz.busy_vec), 64'h0);
    chk("rst_cnt", 64'(hz.outst_cnt), 64'd0);
    chk("rst_stall", 64'(hz.stall_decode), 64'd0);
    chk("rst_flush_e", 64'(hz.flush_execute), 64'd0);
    chk("rst_fwd_d1", 64'(hz.forward_rs1_select_d), 64'd0);
    reset = 1'b0;

    // Load-use: load x5 in E, add rs1=x5 in D.
    hz.mem_load_e = 1; hz.rf_write_en_e = 1; hz.rf_dest_e = 5; hz.rs1_addr_d = 5;
    #1;
    chk("lu_stall_d", 64'(hz.stall_decode), 64'd1);
    chk("lu_stall_f", 64'(hz.stall_fetch), 64'd1);
    chk("lu_flush_e", 64'(hz.flush_execute), 64'd1);
    chk("lu_flush_d", 64'(hz.flush_decode), 64'd0);
    next();
    // Load moved to M, add still in D: no stall, M-load never forwarded.
    clear_inputs();
    hz.rf_dest_m = 5; hz.rf_write_en_m = 1; hz.mem_load_m = 1; hz.rs1_addr_d = 5;
    #1;
    chk("lu_release", 64'(hz.stall_decode), 64'd0);
    chk("mload_no10", 64'(hz.forward_rs1_select_d), 64'd0);
    next();
    // Add in E, load in W; ALU result for x6 sits in M.
    clear_inputs();
    hz.rs1_addr_e = 5; hz.rf_dest_w = 5; hz.rf_write_en_w = 1;
    hz.rs2_addr_e = 6; hz.rf_dest_m = 6; hz.rf_write_en_m = 1;
    #1;
    chk("fwd_e1_w", 64'(hz.forward_rs1_select_e), 64'd1);
    chk("fwd_e2_m", 64'(hz.forward_rs2_select_e), 64'd2);
    // Priority when M, W and long-done all target x3.
    hz.rs1_addr_e = 3; hz.rf_dest_m = 3; hz.rf_dest_w = 3;
    #1;
    chk("prio_m_over_w", 64'(hz.forward_rs1_select_e), 64'd2);
    hz.long_done = 1; hz.long_done_dest = 3;
    #1;
    chk("prio_done", 64'(hz.forward_rs1_select_e), 64'd3);
    hz.long_done = 0; hz.rs1_addr_e = 0; hz.rf_dest_w = 0; hz.rf_dest_m = 0;
    #1;
    chk("fwd_x0", 64'(hz.forward_rs1_select_e), 64'd0);
    next();

    // Mul issue x7, then consumers stall until the edge after done.
    clear_inputs();
    hz.long_issue_e = 1; hz.rf_dest_e = 7;
    next();
    clear_inputs();
    chk("mul_busy", 64'(hz.busy_vec), 64'h80);
    chk("mul_cnt", 64'(hz.outst_cnt), 64'd1);
    hz.rs2_addr_d = 7;
    #1;
    chk("sb_stall", 64'(hz.stall_decode), 64'd1);
    next();
    hz.rs2_addr_d = 0; hz.rs1_addr_d = 7; hz.long_done = 1; hz.long_done_dest = 7;
    #1;
    chk("done_fwd_d", 64'(hz.forward_rs1_select_d), 64'd3);
    chk("done_still_stall", 64'(hz.stall_decode), 64'd1);
    next();
    hz.long_done = 0; hz.long_done_dest = 0;
    #1;
    chk("done_busy", 64'(hz.busy_vec), 64'h0);
    chk("done_cnt", 64'(hz.outst_cnt), 64'd0);
    chk("done_release", 64'(hz.stall_decode), 64'd0);
    clear_inputs();

    // Fill the long unit with x1..x4.
    for (int r = 1; r <= 4; r++) begin
      hz.long_issue_e = 1; hz.rf_dest_e = 5'(r);
      next();
    end
    clear_inputs();
    chk("full_cnt", 64'(hz.outst_cnt), 64'd4);
    chk("full_busy", 64'(hz.busy_vec), 64'h1E);
    hz.long_op_d = 1;
    #1;
    chk("full_stall", 64'(hz.stall_decode), 64'd1);
    hz.long_done = 1; hz.long_done_dest = 1; hz.long_issue_e = 1; hz.rf_dest_e = 8;
    #1;
    chk("full_done_nostall", 64'(hz.stall_decode), 64'd0);
    next();
    clear_inputs();
    chk("swap_cnt", 64'(hz.outst_cnt), 64'd4);
    chk("swap_busy", 64'(hz.busy_vec), 64'h11C);
    // Issue and done for x9 on the same edge: set wins, count unchanged.
    hz.long_issue_e = 1; hz.rf_dest_e = 9; hz.long_done = 1; hz.long_done_dest = 9;
    next();
    clear_inputs();
    chk("same_busy", 64'(hz.busy_vec), 64'h31C);
    chk("same_cnt", 64'(hz.outst_cnt), 64'd4);
    hz.rs1_addr_d = 2;
    #2;
    chk("pre_rst_stall", 64'(hz.stall_decode), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_busy", 64'(hz.busy_vec), 64'h0);
    chk("async_cnt", 64'(hz.outst_cnt), 64'd0);
    chk("async_stall", 64'(hz.stall_decode), 64'd0);
    reset = 1'b0;
    clear_inputs();
    next();

    // Branch resolution in decode.
    hz.branch_inst_d = 1; hz.bj_taken_d = 1; hz.rs1_addr_d = 10;
    #1;
    chk("br_flush", 64'(hz.flush_decode), 64'd1);
    chk("br_nostall", 64'(hz.stall_decode), 64'd0);
    hz.rf_write_en_e = 1; hz.rf_dest_e = 10;
    #1;
    chk("br_e_stall", 64'(hz.stall_decode), 64'd1);
    chk("br_e_noflush", 64'(hz.flush_decode), 64'd0);
    hz.rf_write_en_e = 0; hz.rf_dest_e = 0;
    hz.rs2_addr_d = 11; hz.rf_dest_m = 11; hz.rf_write_en_m = 1; hz.mem_load_m = 1;
    #1;
    chk("br_mload_stall", 64'(hz.stall_decode), 64'd1);
    hz.branch_inst_d = 0;
    #1;
    chk("nonbr_mload", 64'(hz.stall_decode), 64'd0);
    clear_inputs();

    // WAW on a busy destination, then an issue to x0.
    hz.long_issue_e = 1; hz.rf_dest_e = 12;
    next();
    clear_inputs();
    hz.rd_addr_d = 12; hz.rf_write_en_d = 1;
    #1;
    chk("waw_stall", 64'(hz.stall_decode), 64'd1);
    hz.rf_write_en_d = 0;
    #1;
    chk("waw_nowrite", 64'(hz.stall_decode), 64'd0);
    hz.long_issue_e = 1; hz.rf_dest_e = 0;
    next();
    clear_inputs();
    chk("x0_cnt", 64'(hz.outst_cnt), 64'd2);
    chk("x0_busy", 64'(hz.busy_vec), 64'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
